// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: Writeback has fixed priority over a small
// in-order long-unit result buffer. Optional starvation guard: WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [63:0] lu_data,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [63:0] rf_wd,
    input  logic [4:0]  q_rd,
    output logic        q_hit,
    output logic        stall_req
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [4:0]    XZR     = 5'd31;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_WB,
        GNT_BUF
    } grant_e;

    logic [DEPTH-1:0] valid;
    logic [4:0]       rd_mem   [DEPTH];
    logic [63:0]      data_mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic   empty;
    logic   head_valid;
    logic   enq;
    logic   store;
    logic   wb_grant;
    logic   pop;
    logic   stall_grant;
    logic   kill_enq;
    grant_e grant;

    assign lu_ready   = resetl && (count < DEPTH_C);
    assign empty      = (count == '0);
    assign head_valid = !empty && valid[rd_ptr];
    assign enq        = lu_valid && lu_ready;
    assign store      = enq && (lu_rd != XZR);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant       = GNT_IDLE;
        pop         = 1'b0;
        stall_grant = stall_req && head_valid;
        if (stall_grant) begin
            grant = GNT_BUF;
            pop   = 1'b1;
        end else if (wb_regwrite && (wb_rd != XZR)) begin
            grant = GNT_WB;
        end else if (!empty) begin
            // An invalidated head is popped without a register-file write.
            pop = 1'b1;
            if (head_valid) grant = GNT_BUF;
        end
    end

    assign wb_grant = (grant == GNT_WB);
    // The long-unit result is older than a same-cycle Writeback to the same register.
    assign kill_enq = wb_grant && (lu_rd == wb_rd);

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (rd_mem[i] == q_rd)) q_hit = 1'b1;
        end
        q_hit = q_hit && resetl && (q_rd != XZR);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetl) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_grant && (rd_mem[i] == wb_rd)) valid[i] <= 1'b0;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (store) begin
                valid[wr_ptr] <= !kill_enq;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            count <= count + CW'(store) - CW'(pop);
        end
    end

    // NOTE: the payload array is not reset; the valid bits alone decide whether an entry means anything.
    always_ff @(posedge clk) begin
        if (store) begin
            rd_mem[wr_ptr]   <= lu_rd;
            data_mem[wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            unique case (grant)
                GNT_WB: begin
                    rf_we <= 1'b1;
                    rf_wa <= wb_rd;
                    rf_wd <= wb_data;
                end
                GNT_BUF: begin
                    rf_we <= 1'b1;
                    rf_wa <= rd_mem[rd_ptr];
                    rf_wd <= data_mem[rd_ptr];
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_cnt_next;

    // Saturates at the limit; any buffer pop restarts the count.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (pop) begin
            starve_cnt_next = '0;
        end else if (head_valid && wb_grant && (starve_cnt != STARVE_C)) begin
            starve_cnt_next = starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_next;
            stall_req  <= !pop && (stall_req || (starve_cnt_next == STARVE_C));
        end
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = |STARVE_MAX;
    assign stall_req         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH = 2, STARVE_MAX = 8).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        resetl;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [63:0] lu_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [63:0] rf_wd;
    logic [4:0]  q_rd;
    logic        q_hit;
    logic        stall_req;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .resetl     (resetl),
        .wb_regwrite(wb_regwrite),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .q_rd       (q_rd),
        .q_hit      (q_hit),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [4:0] wa, input logic [63:0] wd);
        check({tag, ".we"}, 64'(rf_we), 64'd1);
        check({tag, ".wa"}, 64'(rf_wa), 64'(wa));
        check({tag, ".wd"}, rf_wd, wd);
    endtask

    task automatic query(input string tag, input logic [4:0] rd, input logic exp);
        q_rd = rd;
        #1;
        check(tag, 64'(q_hit), 64'(exp));
    endtask

    initial begin
        resetl      = 1'b0;
        wb_regwrite = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        lu_valid    = 1'b0;
        lu_rd       = '0;
        lu_data     = '0;
        q_rd        = '0;

        // Reset held for two cycles.
        tick();
        tick();
        check("rst.we", 64'(rf_we), 64'd0);
        check("rst.wa", 64'(rf_wa), 64'd0);
        check("rst.wd", rf_wd, 64'd0);
        check("rst.stall", 64'(stall_req), 64'd0);
        check("rst.lu_ready", 64'(lu_ready), 64'd0);
        check("rst.q_hit", 64'(q_hit), 64'd0);
        resetl = 1'b1;
        #1;
        check("rel.lu_ready", 64'(lu_ready), 64'd1);
        check("rel.q_hit", 64'(q_hit), 64'd0);

        // Writeback wins over a same-cycle enqueue; buffered result follows.
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 64'd56;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 64'd98;
        tick();
        check_write("prio.wb", 5'd3, 64'd56);
        query("prio.q7_pending", 5'd7, 1'b1);
        wb_regwrite = 1'b0; lu_valid = 1'b0;
        tick();
        check_write("prio.buf", 5'd7, 64'd98);
        query("prio.q7_gone", 5'd7, 1'b0);
        tick();
        check("prio.idle", 64'(rf_we), 64'd0);

        // XZR: Writeback to 31 dropped, long-unit result to 31 not stored.
        wb_regwrite = 1'b1; wb_rd = 5'd31; wb_data = 64'd99;
        tick();
        check("xzr.wb_drop", 64'(rf_we), 64'd0);
        lu_valid = 1'b1; lu_rd = 5'd31; lu_data = 64'd123;
        #1;
        check("xzr.lu_ready", 64'(lu_ready), 64'd1);
        tick();
        check("xzr.lu_no_write", 64'(rf_we), 64'd0);
        query("xzr.q31", 5'd31, 1'b0);
        wb_regwrite = 1'b0; lu_valid = 1'b0;
        tick();
        check("xzr.no_phantom_pop", 64'(rf_we), 64'd0);
        check("xzr.count_kept", 64'(lu_ready), 64'd1);

        // Stale kill by a younger Writeback in the following cycle.
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 64'h11;
        tick();
        check("kill.enq_no_write", 64'(rf_we), 64'd0);
        query("kill.q5_pending", 5'd5, 1'b1);
        lu_valid = 1'b0;
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 64'h22;
        tick();
        check_write("kill.wb", 5'd5, 64'h22);
        query("kill.q5_killed", 5'd5, 1'b0);
        wb_regwrite = 1'b0;
        tick();
        check("kill.silent_pop", 64'(rf_we), 64'd0);
        tick();
        check("kill.idle", 64'(rf_we), 64'd0);

        // Same-cycle enqueue and Writeback to the same register.
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'h90;
        wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
        tick();
        check_write("samecyc.wb", 5'd9, 64'h99);
        query("samecyc.q9", 5'd9, 1'b0);
        lu_valid = 1'b0; wb_regwrite = 1'b0;
        tick();
        check("samecyc.silent_pop", 64'(rf_we), 64'd0);

        // Fill, backpressure, drain in order with pointer wrap.
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 64'h100;
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 64'hA0;
        tick();
        check_write("full.wb0", 5'd1, 64'h100);
        check("full.ready_after1", 64'(lu_ready), 64'd1);
        lu_rd = 5'd11; lu_data = 64'hA1; wb_data = 64'h101;
        tick();
        check_write("full.wb1", 5'd1, 64'h101);
        check("full.ready_after2", 64'(lu_ready), 64'd0);
        lu_rd = 5'd12; lu_data = 64'hA2; wb_data = 64'h102;
        tick();
        check_write("full.wb2", 5'd1, 64'h102);
        check("full.still_full", 64'(lu_ready), 64'd0);
        query("full.q12_rejected", 5'd12, 1'b0);
        query("full.q10_pending", 5'd10, 1'b1);
        query("full.q11_pending", 5'd11, 1'b1);
        check("full.stall_idle", 64'(stall_req), 64'd0);
        wb_regwrite = 1'b0;
        tick();
        check_write("full.drain0", 5'd10, 64'hA0);
        check("full.ready_after_pop", 64'(lu_ready), 64'd1);
        tick();
        check_write("full.drain1", 5'd11, 64'hA1);
        lu_valid = 1'b0;
        tick();
        check_write("full.drain2", 5'd12, 64'hA2);
        query("full.q12_gone", 5'd12, 1'b0);
        tick();
        check("full.empty", 64'(rf_we), 64'd0);
        check("full.ready_empty", 64'(lu_ready), 64'd1);

`ifdef WB_ARB_STARVE_GUARD_EN
        // Starvation guard: buffer head denied by a continuous Writeback stream.
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 64'h200;
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 64'hBEEF;
        tick();
        check_write("guard.wb_enq", 5'd2, 64'h200);
        lu_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_write("guard.denied", 5'd2, 64'h200);
            check("guard.stall_ramp", 64'(stall_req), 64'(i == 8));
        end
        wb_data = 64'h77;
        tick();
        check_write("guard.forced", 5'd20, 64'hBEEF);
        check("guard.stall_fall", 64'(stall_req), 64'd0);
        tick();
        check_write("guard.wb_replay", 5'd2, 64'h77);
        check("guard.stall_low", 64'(stall_req), 64'd0);
        wb_regwrite = 1'b0;
        tick();
        check("guard.idle", 64'(rf_we), 64'd0);
`endif

        // Reset mid-flight discards buffered entries.
        lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 64'hE0;
        wb_regwrite = 1'b1; wb_rd = 5'd4; wb_data = 64'h40;
        tick();
        lu_valid = 1'b0; wb_regwrite = 1'b0;
        resetl = 1'b0;
        tick();
        check("rst2.we", 64'(rf_we), 64'd0);
        check("rst2.q_hit", 64'(q_hit), 64'd0);
        resetl = 1'b1;
        tick();
        check("rst2.discarded", 64'(rf_we), 64'd0);
        query("rst2.q14", 5'd14, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

- Arbitrates the single register-file write port between two sources:
  - the in-order Writeback stage, which has fixed priority;
  - a long-latency functional unit (multiply/divide) result stream, queued in a small in-order buffer.
- Drops writes to X31 (XZR).
- Kills buffered results made stale by a younger Writeback write to the same register.
- Provides a pending-register query for the hazard unit.
- Sits between the Writeback stage and the register file.

## Interface
Parameters:
- DEPTH, 2, long-unit buffer entries; legal values are 2 or 4.
- STARVE_MAX, 8, consecutive denied cycles before a forced drain (guard build only).

Ports:
- clk  in  1  rising-edge clock.
- resetl  in  1  reset; one clock, synchronous, active-low.
- wb_regwrite  in  1  Writeback stage requests a register write this cycle.
- wb_rd  in  5  Writeback destination register.
- wb_data  in  64  Writeback data, already Mem2Reg-muxed.
- lu_valid  in  1  long-unit result valid.
- lu_ready  out  1  buffer can accept; equals resetl && (count < DEPTH).
- lu_rd  in  5  long-unit destination register.
- lu_data  in  64  long-unit result.
- rf_we  out  1  register-file write enable (registered).
- rf_wa  out  5  register-file write address (registered).
- rf_wd  out  64  register-file write data (registered).
- q_rd  in  5  hazard-unit query register.
- q_hit  out  1  combinational; 1 when any valid buffer entry has rd == q_rd and q_rd != 31.
- stall_req  out  1  registered; requests the hazard unit to hold the Writeback stage for one cycle.

## Operation
- Buffer: DEPTH-entry circular FIFO; each entry holds {valid, rd, data}.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is (log2(DEPTH)+1) bits.
- Enqueue: on lu_valid && lu_ready.
  - If lu_rd == 31, the handshake completes but nothing is stored.
- Grant priority, evaluated each cycle:
  1. If stall_req == 1 and the buffer head is valid, grant the buffer; Writeback is ignored this cycle.
  2. Else if wb_regwrite && wb_rd != 31, grant Writeback.
  3. Else if the buffer is non-empty, pop the head. Write only if the head's valid bit is set; an invalidated head is popped silently.
  4. Else idle: rf_we = 0.
- Staleness kill:
  - When Writeback is granted, every buffer entry with rd == wb_rd has its valid bit cleared in the same cycle.
  - A same-cycle enqueue with lu_rd == wb_rd is stored with valid = 0. The long-unit result is the older one.
- Simultaneous enqueue and pop: both occur and count is unchanged.
  - When full, lu_ready = 0, so a same-cycle pop does not admit a new entry. There is no combinational pass-through.
- Reset (resetl low at a posedge) clears the following, regardless of in-flight entries, which are discarded:
  - count, both pointers and all valid bits;
  - the starvation counter;
  - rf_we = 0, rf_wa = 0, rf_wd = 0;
  - stall_req = 0.
- lu_ready and q_hit read 0 while resetl is low.

## Timing
- Latency: inputs are sampled at posedge N; rf_we/rf_wa/rf_wd are valid after posedge N and the register file commits at posedge N+1.
- Buffered result, minimum path: enqueued at posedge N, written out at the earliest on grant at posedge N+1, visible on rf_* after N+1.
- q_hit reflects buffer state after the most recent posedge. Entries popped or killed at posedge N stop hitting after posedge N.
- lu_ready drops in the cycle after the enqueue that fills the buffer, and rises in the cycle after a pop.
- The first posedge with resetl high already accepts requests.

## Configuration
- WB_ARB_STARVE_GUARD_EN defined:
  - A starvation counter increments each cycle the buffer head is valid but Writeback is granted, and clears on any buffer grant.
  - When the counter reaches STARVE_MAX, stall_req is set at the next posedge.
  - stall_req stays high until the cycle in which the buffer is granted. It clears at that posedge, and the counter resets with it.
  - During a stall cycle there is no Writeback write and no staleness kill. The hazard unit re-presents the same Writeback inputs in the next cycle.
- WB_ARB_STARVE_GUARD_EN undefined:
  - No counter is built and stall_req is tied to 0.
  - The buffer may starve indefinitely; backpressure reaches the long unit via lu_ready only.

## Test plan
- Reset then idle: resetl low for 2 cycles → rf_we = 0, rf_wa = 0, rf_wd = 0, stall_req = 0, lu_ready = 0. After release: lu_ready = 1, q_hit = 0.
- Writeback priority:
  - Same cycle: wb_regwrite = 1, wb_rd = 3, wb_data = 56, and a long-unit enqueue with lu_rd = 7, lu_data = 98.
  - Expected: next cycle rf_wa = 3, rf_wd = 56; with Writeback idle, the following cycle rf_wa = 7, rf_wd = 98.
  - q_hit(7) = 1 until that pop.
- XZR drop: wb_rd = 31 with wb_regwrite = 1 → rf_we = 0. An lu_rd = 31 enqueue completes with count unchanged.
- Stale kill:
  - Enqueue lu_rd = 5, lu_data = 0x11.
  - Next cycle grant Writeback with wb_rd = 5, wb_data = 0x22.
  - Expected: only one write occurs, rf_wd = 0x22; the head pops silently; q_hit(5) = 0 afterwards.
- Full/wrap (DEPTH = 2): hold wb_regwrite = 1 and offer 3 long-unit results → lu_ready = 0 after 2 enqueues. After release, the entries drain in order, the third is accepted, and pointers wrap correctly over 6 pushes.
- Guard build (STARVE_MAX = 8): buffer non-empty with wb_regwrite = 1 continuously.
  - stall_req rises after 8 denied cycles.
  - The next cycle writes the buffer head, then stall_req falls.
  - Writeback data presented during the stall is written the following cycle.
